// File: rtl/contador_pkg.sv
// Shared types and constants for the contador_sched round-robin counter scheduler.
package contador_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } sched_state_t;

    localparam logic DIR_UP   = 1'b0;
    localparam logic DIR_DOWN = 1'b1;

endpackage

// File: rtl/contador_sched_updown_core.sv
// Shared N-bit up/down counter datapath; load has priority over count enable.
module updown_core
    import contador_pkg::*;
#(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [N-1:0] load_val,
    input  logic         en,
    input  logic         dir,
    output logic [N-1:0] q
);

    localparam logic [N-1:0] ONE = {{(N-1){1'b0}}, 1'b1};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q <= '0;
        end else if (load) begin
            q <= load_val;
        end else if (en) begin
            q <= (dir == DIR_DOWN) ? (q - ONE) : (q + ONE);
        end
    end

endmodule

// File: rtl/contador_sched.sv
// Round-robin scheduler sharing one up/down counter among NREQ requesters.
// Optional abort feature: define CONTADOR_SCHED_ABORT_EN to add abort/aborted ports.
//
// state | meaning
// IDLE  | waiting for any req; grants the round-robin winner and loads start value
// RUN   | counter stepping toward end value (held while pause)
// DONE  | one-cycle completion pulse with done_id, then back to IDLE
module contador_sched
    import contador_pkg::*;
#(
    parameter int N    = 8,
    parameter int NREQ = 2
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic [NREQ-1:0]                      req,
    input  logic [NREQ-1:0]                      dir,
    input  logic [NREQ*N-1:0]                    len,
    input  logic                                 pause,
`ifdef CONTADOR_SCHED_ABORT_EN
    input  logic                                 abort,
    output logic                                 aborted,
`endif
    output logic [NREQ-1:0]                      gnt,
    output logic                                 busy,
    output logic [N-1:0]                         q,
    output logic                                 done,
    output logic [((NREQ > 1) ? $clog2(NREQ) : 1)-1:0] done_id
);

    localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;

    // First set request at or after the pointer, wrapping around.
    function automatic logic [IDW-1:0] rr_pick(input logic [NREQ-1:0] r, input logic [IDW-1:0] p);
        logic [IDW-1:0] w;
        logic           found;
        int             c;
        w     = '0;
        found = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            c = (int'(p) + k) % NREQ;
            if (!found && r[c]) begin
                w     = IDW'(c);
                found = 1'b1;
            end
        end
        return w;
    endfunction

    sched_state_t   state, state_nxt;
    logic [IDW-1:0] ptr;
    logic [IDW-1:0] win_id;
    logic           win_dir;
    logic [N-1:0]   end_val;

    logic [IDW-1:0] win;
    logic [N-1:0]   win_len;
    logic           grant;
    logic           load;
    logic [N-1:0]   load_val;
    logic           en;

    assign win     = rr_pick(req, ptr);
    assign win_len = len[int'(win)*N +: N];

    always_comb begin
        state_nxt = state;
        grant     = 1'b0;
        load      = 1'b0;
        load_val  = '0;
        en        = 1'b0;
        case (state)
            IDLE: begin
                if (|req) begin
                    grant     = 1'b1;
                    load      = 1'b1;
                    load_val  = (dir[win] == DIR_DOWN) ? win_len : '0;
                    state_nxt = RUN;
                end
            end
            RUN: begin
`ifdef CONTADOR_SCHED_ABORT_EN
                if (abort) begin
                    state_nxt = DONE;
                end else
`endif
                if (pause) begin
                    state_nxt = RUN;
                end else if (q == end_val) begin
                    state_nxt = DONE;
                end else begin
                    en = 1'b1;
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            ptr     <= '0;
            win_id  <= '0;
            win_dir <= DIR_UP;
            end_val <= '0;
        end else begin
            state <= state_nxt;
            if (grant) begin
                ptr     <= IDW'((int'(win) + 1) % NREQ);
                win_id  <= win;
                win_dir <= dir[win];
                end_val <= (dir[win] == DIR_DOWN) ? '0 : win_len;
            end
        end
    end

`ifdef CONTADOR_SCHED_ABORT_EN
    logic abort_flag;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            abort_flag <= 1'b0;
        end else if (state == RUN) begin
            abort_flag <= abort;
        end
    end

    assign aborted = (state == DONE) && abort_flag;
`endif

    always_comb begin
        gnt = '0;
        if (state == RUN) begin
            gnt[win_id] = 1'b1;
        end
    end

    assign busy    = (state == RUN);
    assign done    = (state == DONE);
    assign done_id = done ? win_id : '0;

    updown_core #(.N(N)) u_core (
        .clk      (clk),
        .reset    (reset),
        .load     (load),
        .load_val (load_val),
        .en       (en),
        .dir      (win_dir),
        .q        (q)
    );

endmodule

// File: tb/tb_contador_sched.sv
// Directed bench for contador_sched (N=8, NREQ=2); abort checks need CONTADOR_SCHED_ABORT_EN.
module tb_contador_sched;

    logic        clk;
    logic        reset;
    logic [1:0]  req;
    logic [1:0]  dir;
    logic [15:0] len;
    logic        pause;
    logic        abort_s;
    logic        aborted_s;
    logic [1:0]  gnt;
    logic        busy;
    logic [7:0]  q;
    logic        done;
    logic [0:0]  done_id;

    int n_vec;
    int n_err;

    contador_sched #(.N(8), .NREQ(2)) dut (
        .clk     (clk),
        .reset   (reset),
        .req     (req),
        .dir     (dir),
        .len     (len),
        .pause   (pause),
`ifdef CONTADOR_SCHED_ABORT_EN
        .abort   (abort_s),
        .aborted (aborted_s),
`endif
        .gnt     (gnt),
        .busy    (busy),
        .q       (q),
        .done    (done),
        .done_id (done_id)
    );

`ifndef CONTADOR_SCHED_ABORT_EN
    assign aborted_s = 1'b0;
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  req;
        logic [1:0]  dir;
        logic [15:0] len;
        logic        pause;
        logic [1:0]  gnt;
        logic        busy;
        logic [7:0]  q;
        logic        done;
        logic        did;
    } vec_t;

    vec_t tbl[16];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (!reset && gnt == 2'b11) begin
            n_err++;
            $display("FAIL gnt_onehot: got %b expected at most one bit at %0t", gnt, $time);
        end
    end

    initial begin
        int cnt;
        n_vec   = 0;
        n_err   = 0;
        reset   = 1'b1;
        req     = '0;
        dir     = '0;
        len     = '0;
        pause   = 1'b0;
        abort_s = 1'b0;

        // single up run on requester 0, then paused down run on requester 1
        tbl[0]  = '{2'b01, 2'b00, 16'h0005, 1'b0, 2'b01, 1'b1, 8'd0, 1'b0, 1'b0};
        tbl[1]  = '{2'b00, 2'b00, 16'h0005, 1'b0, 2'b01, 1'b1, 8'd1, 1'b0, 1'b0};
        tbl[2]  = '{2'b00, 2'b00, 16'h0005, 1'b0, 2'b01, 1'b1, 8'd2, 1'b0, 1'b0};
        tbl[3]  = '{2'b00, 2'b00, 16'h0005, 1'b0, 2'b01, 1'b1, 8'd3, 1'b0, 1'b0};
        tbl[4]  = '{2'b00, 2'b00, 16'h0005, 1'b0, 2'b01, 1'b1, 8'd4, 1'b0, 1'b0};
        tbl[5]  = '{2'b00, 2'b00, 16'h0005, 1'b0, 2'b01, 1'b1, 8'd5, 1'b0, 1'b0};
        tbl[6]  = '{2'b00, 2'b00, 16'h0005, 1'b0, 2'b00, 1'b0, 8'd5, 1'b1, 1'b0};
        tbl[7]  = '{2'b00, 2'b00, 16'h0005, 1'b0, 2'b00, 1'b0, 8'd5, 1'b0, 1'b0};
        tbl[8]  = '{2'b10, 2'b10, 16'h0300, 1'b0, 2'b10, 1'b1, 8'd3, 1'b0, 1'b0};
        tbl[9]  = '{2'b00, 2'b10, 16'h0300, 1'b0, 2'b10, 1'b1, 8'd2, 1'b0, 1'b0};
        tbl[10] = '{2'b00, 2'b10, 16'h0300, 1'b1, 2'b10, 1'b1, 8'd2, 1'b0, 1'b0};
        tbl[11] = '{2'b00, 2'b10, 16'h0300, 1'b1, 2'b10, 1'b1, 8'd2, 1'b0, 1'b0};
        tbl[12] = '{2'b00, 2'b10, 16'h0300, 1'b0, 2'b10, 1'b1, 8'd1, 1'b0, 1'b0};
        tbl[13] = '{2'b00, 2'b10, 16'h0300, 1'b0, 2'b10, 1'b1, 8'd0, 1'b0, 1'b0};
        tbl[14] = '{2'b00, 2'b10, 16'h0300, 1'b0, 2'b00, 1'b0, 8'd0, 1'b1, 1'b1};
        tbl[15] = '{2'b00, 2'b10, 16'h0300, 1'b0, 2'b00, 1'b0, 8'd0, 1'b0, 1'b0};

        step();
        step();
        chk("rst_gnt", 32'(gnt), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_q", 32'(q), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_done_id", 32'(done_id), 32'd0);
        #3 reset = 1'b0;

        for (int i = 0; i < 16; i++) begin
            req   = tbl[i].req;
            dir   = tbl[i].dir;
            len   = tbl[i].len;
            pause = tbl[i].pause;
            step();
            chk($sformatf("v%0d_gnt", i), 32'(gnt), 32'(tbl[i].gnt));
            chk($sformatf("v%0d_busy", i), 32'(busy), 32'(tbl[i].busy));
            chk($sformatf("v%0d_q", i), 32'(q), 32'(tbl[i].q));
            chk($sformatf("v%0d_done", i), 32'(done), 32'(tbl[i].done));
            if (tbl[i].done) chk($sformatf("v%0d_done_id", i), 32'(done_id), 32'(tbl[i].did));
        end

        // round-robin contention: pointer is 0 after requester 1 finished
        req = 2'b11;
        dir = 2'b00;
        len = 16'h0101;
        for (int k = 0; k < 4; k++) begin
            step();
            chk($sformatf("rr%0d_gnt", k), 32'(gnt), 32'(2'b01 << (k % 2)));
            step();
            chk($sformatf("rr%0d_q", k), 32'(q), 32'd1);
            step();
            chk($sformatf("rr%0d_done", k), 32'(done), 32'd1);
            chk($sformatf("rr%0d_done_id", k), 32'(done_id), 32'(k % 2));
            step();
            chk($sformatf("rr%0d_idle", k), 32'({done, busy, gnt}), 32'd0);
        end

        // len=0: done right after the grant cycle
        req = 2'b01;
        len = 16'h0000;
        step();
        chk("len0_gnt", 32'(gnt), 32'b01);
        chk("len0_q", 32'(q), 32'd0);
        req = 2'b00;
        step();
        chk("len0_done", 32'(done), 32'd1);
        chk("len0_qend", 32'(q), 32'd0);
        step();

        // len=255 up: no wrap, done 256 edges after the grant edge
        req = 2'b01;
        len = 16'h00FF;
        step();
        req = 2'b00;
        chk("len255_start", 32'(q), 32'd0);
        cnt = 0;
        while (!done && cnt < 400) begin
            step();
            cnt++;
            if (cnt == 255) chk("len255_top", 32'(q), 32'd255);
        end
        chk("len255_latency", 32'(cnt), 32'd256);
        chk("len255_qend", 32'(q), 32'd255);
        step();

        // reset mid-run of requester 0 (pointer points at 1 when reset hits)
        req = 2'b01;
        len = 16'h0005;
        step();
        req = 2'b00;
        step();
        step();
        step();
        chk("mid_q3", 32'(q), 32'd3);
        #3 reset = 1'b1;
        #1;
        chk("mid_rst_q", 32'(q), 32'd0);
        chk("mid_rst_gnt_busy", 32'({gnt, busy}), 32'd0);
        chk("mid_rst_done", 32'(done), 32'd0);
        step();
        chk("mid_rst_nodone", 32'(done), 32'd0);
        #3 reset = 1'b0;
        req = 2'b11;
        len = 16'h0202;
        step();
        chk("mid_rst_ptr", 32'(gnt), 32'b01);
        req = 2'b00;
        step();
        step();
        step();
        chk("mid_rst_rundone", 32'(done), 32'd1);
        step();

`ifdef CONTADOR_SCHED_ABORT_EN
        // abort at q=2 of an up run with len=6
        req = 2'b01;
        len = 16'h0006;
        step();
        req = 2'b00;
        step();
        step();
        chk("abort_q2", 32'(q), 32'd2);
        abort_s = 1'b1;
        step();
        abort_s = 1'b0;
        chk("abort_done", 32'(done), 32'd1);
        chk("abort_aborted", 32'(aborted_s), 32'd1);
        chk("abort_q", 32'(q), 32'd2);
        step();
        chk("abort_clear", 32'({done, aborted_s}), 32'd0);
`else
        chk("no_abort_flag", 32'(aborted_s), 32'd0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/contador_sched.md
# contador_sched

Round-robin scheduler that shares one N-bit up/down counter among NREQ requesters. Each requester asks for a counting run with its own direction and length. The scheduler grants one requester at a time, sequences the counter from start value to end value, and signals completion. It sits above the up/down counter datapath and is the only block that drives its load, enable and direction controls.

## Interface
- N, default 8: counter width in bits.
- NREQ, default 2: number of requesters (2..8).
- clk  in  1  clock; all state changes on its rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- req  in  NREQ  per-requester run request (level).
- dir  in  NREQ  per-requester direction; 0 = up, 1 = down.
- len  in  NREQ*N  per-requester run length; requester i uses bits [i*N +: N].
- pause  in  1  freezes the active run while high.
- gnt  out  NREQ  one-hot grant; high for the whole run.
- busy  out  1  high while a run is active.
- q  out  N  shared counter value.
- done  out  1  one-cycle completion pulse.
- done_id  out  max(1,$clog2(NREQ))  index of the requester whose run just finished; valid while done=1.

## Operation
- States: IDLE, RUN, DONE.
- Reset values: state=IDLE, q=0, gnt=0, busy=0, done=0, done_id=0, round-robin pointer=0 (requester 0 has highest priority).
- IDLE, no req: hold; q keeps its last value.
- IDLE, any req set:
  - The winner is the first set req at or after the pointer, wrapping around.
  - Latch the winner's index, dir[i] and len[i]; later changes to them are ignored until the next grant.
  - Load q with the start value: 0 for up, len for down. End value: len for up, 0 for down.
  - Set gnt[i]=1 and busy=1, go to RUN.
  - Set the pointer to winner+1 mod NREQ.
- RUN:
  - pause=1 has top priority: q and state hold.
  - Otherwise, q==end goes to DONE with q unchanged.
  - Otherwise, q steps by +1 (up) or -1 (down), modulo 2^N.
- DONE:
  - done=1 and done_id=winner for exactly this cycle.
  - gnt=0 and busy=0; q holds the end value.
  - Go to IDLE.
- req is sampled only in IDLE. A requester that keeps req high after its done competes again, at lowest priority.
- Reset asserted mid-run: immediate abort, all outputs go to reset values, and no done is issued.

## Timing
- Grant latency: req high in IDLE before edge t0 gives gnt, busy and q=start visible after t0.
- Unpaused run of length L: q takes values start through end on edges t0..tL.
- Edge tL+1 enters DONE, so done is high in the cycle after tL+1. Total is L+2 cycles from grant edge to done.
- len=0: start==end, so done follows at t0+1. Total is 2 cycles.
- Each pause cycle adds exactly one cycle to the run length.
- Minimum spacing between back-to-back grants: a new grant edge occurs at the DONE→IDLE edge + 1.
- len=2^N-1 is legal, with no wrap during the run.

## Configuration
- CONTADOR_SCHED_ABORT_EN defined:
  - Adds input `abort` (1 bit) and output `aborted` (1 bit).
  - abort=1 in RUN, with priority over pause, goes to DONE next edge with q frozen. done=1 and aborted=1 for that DONE cycle.
  - abort is ignored outside RUN.
- Macro undefined: no abort port, no aborted port; runs always complete.

## Structure
- Package contador_pkg holds:
  - State enum sched_state_t {IDLE, RUN, DONE}.
  - Constants DIR_UP=1'b0 and DIR_DOWN=1'b1.
- Sub-module updown_core (N):
  - Synchronous counter with ports clk, reset, load, load_val, en, dir, q.
  - The scheduler drives load in IDLE-grant and en in unpaused RUN steps.
- The round-robin picker is a function inside contador_sched, not a separate module.

## Test plan
- **Single up run:** N=8, req[0]=1, dir[0]=0, len[0]=5 → gnt=01 after 1 edge; q=0,1,2,3,4,5; done with done_id=0 exactly 7 cycles after the req edge; q holds 5.
- **Down run with pause:** req[1]=1, dir[1]=1, len[1]=3; pause=1 for 2 cycles mid-run → q=3,2,(2,2),1,0; done 2 cycles later than unpaused; gnt=10 throughout.
- **Round-robin contention:** req=11 held continuously, len=1 for both → grants alternate 0,1,0,1; done_id alternates accordingly; no cycle with both gnt bits set.
- **Edge cases:** len=0 → done at t0+1 with q=0. len=255 up → q reaches 255 with no wrap; done after 257 cycles.
- **Reset mid-run:** reset during RUN with q=3 → q=0, gnt=0, busy=0 immediately; no done pulse; next request from requester 1 still loses to requester 0 when both are requesting.
- **Abort (macro defined):** abort at q=2 of an up run with len=6 → DONE next edge, done=aborted=1, q=2.
